seg_decoder: RTL

- Receive-side counterpart of the multiplexed 6-digit seven-segment display bus.
- Samples the scanned sel/dig lines, decodes each active-low segment pattern back to a BCD digit, and assembles one HH:MM:SS frame.
- Converts the frame to a 17-bit seconds-of-day value, the same format the time counter feeds the display driver.
- Used for display loopback checking and for capturing time from an external display-bus source.

---
 rtl/seg_decoder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_decoder.sv
// seg_decoder: receive side of the multiplexed 6-digit seven-segment bus.
// Samples the scanned digit select and segment lines, decodes each stable
// digit back to BCD, assembles an HH:MM:SS frame and converts it to a
// 17-bit seconds-of-day value.
//
// Ports:
//   clk      - system clock
//   rst_n    - synchronous reset, active low
//   sel      - digit select, active-low one-hot; [5]..[0] = Ht,Hu,Mt,Mu,St,Su
//   dig      - segments, active low; [6:0] = g..a, [7] = dp (not decoded)
//   dout     - last accepted time in seconds, 0..86399
//   dout_vld - one-cycle pulse, dout updated this cycle
//   err      - one-cycle pulse, frame rejected (pattern, range or timeout)
module seg_decoder #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned FRAME_TO = 600_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  sel,
  input  logic [7:0]  dig,
  output logic [16:0] dout,
  output logic        dout_vld,
  output logic        err
);

  localparam int unsigned STW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int unsigned TW  = (FRAME_TO < 1) ? 1 : $clog2(FRAME_TO + 1);
  localparam logic [STW-1:0] SETTLE_C   = STW'(SETTLE);
  localparam logic [TW-1:0]  FRAME_TO_C = TW'(FRAME_TO);

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    SUM,
    OUT
  } state_t;

  // {bad, code}; illegal patterns decode to code 0 with bad set
  function automatic logic [4:0] seg_to_bcd(input logic [6:0] pat);
    case (pat)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      default: return 5'h10;
    endcase
  endfunction

  // tens*10 + units as (t<<3)+(t<<1)+u
  function automatic logic [6:0] two_digit(input logic [3:0] t, input logic [3:0] u);
    logic [6:0] tx;
    tx = {3'b000, t};
    return (tx << 3) + (tx << 1) + {3'b000, u};
  endfunction

  // h*3600 + m*60 + s; 3600 = 2048+1024+512+16, 60 = 32+16+8+4
  function automatic logic [16:0] to_seconds(input logic [6:0] h,
                                             input logic [6:0] m,
                                             input logic [6:0] s);
    logic [16:0] hx, mx, sx;
    hx = {10'd0, h};
    mx = {10'd0, m};
    sx = {10'd0, s};
    return (hx << 11) + (hx << 10) + (hx << 9) + (hx << 4)
         + (mx << 5) + (mx << 4) + (mx << 3) + (mx << 2) + sx;
  endfunction

  // Input sampling and settle tracking
  logic [5:0]     sel_q, sel_p_q;
  logic [7:0]     dig_q, dig_p_q;
  logic [STW-1:0] stab_q, stab_d;
  logic           cap_done_q, cap_done_d;
  logic           changed, sel_ok, cap;
  logic [4:0]     dec;

  // Frame state
  state_t        state_q, state_d;
  logic [5:0]    mask_q, mask_d;
  logic [5:0]    bad_q, bad_d;
  logic [3:0]    code_q [6];
  logic [3:0]    code_d [6];
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    h_q, h_d, m_q, m_d, s_q, s_d;
  logic [16:0]   dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign err      = err_q;

  always_comb begin
    changed = (sel_q != sel_p_q) || (dig_q != dig_p_q);
    sel_ok  = $onehot(~sel_q);
    dec     = seg_to_bcd(dig_q[6:0]);
    // cap_done limits each dwell to a single capture
    cap     = sel_ok && !changed && (stab_q == SETTLE_C) && !cap_done_q;

    stab_d     = stab_q;
    cap_done_d = cap_done_q;
    if (changed || !sel_ok) begin
      stab_d     = '0;
      cap_done_d = 1'b0;
    end else begin
      if (stab_q != SETTLE_C) stab_d = stab_q + 1'b1;
      if (cap) cap_done_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bad_d   = bad_q;
    code_d  = code_q;
    timer_d = timer_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      COLLECT: begin
        if (timer_q == FRAME_TO_C) begin
          mask_d  = '0;
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          if (cap) begin
            mask_d = mask_q | ~sel_q;
            for (int unsigned i = 0; i < 6; i++) begin
              if (!sel_q[i]) begin
                code_d[i] = dec[3:0];
                bad_d[i]  = dec[4];
              end
            end
          end
          if (mask_d == 6'h3F) begin
            state_d = CHECK;
            timer_d = '0;
          end else if (mask_d != '0) begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      CHECK: begin
        h_d = two_digit(code_q[5], code_q[4]);
        m_d = two_digit(code_q[3], code_q[2]);
        s_d = two_digit(code_q[1], code_q[0]);
        if ((bad_q != '0) || (h_d > 7'd23) || (m_d > 7'd59) || (s_d > 7'd59)) begin
          err_d   = 1'b1;
          mask_d  = '0;
          state_d = COLLECT;
        end else begin
          state_d = SUM;
        end
      end
      SUM: begin
        // Result is written straight into the output register so that
        // dout and dout_vld are both presented during OUT.
        dout_d  = to_seconds(h_q, m_q, s_q);
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        mask_d  = '0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= '1;
      sel_p_q    <= '1;
      dig_q      <= '1;
      dig_p_q    <= '1;
      stab_q     <= '0;
      cap_done_q <= 1'b0;
      state_q    <= COLLECT;
      mask_q     <= '0;
      bad_q      <= '0;
      for (int unsigned i = 0; i < 6; i++) code_q[i] <= '0;
      timer_q    <= '0;
      h_q        <= '0;
      m_q        <= '0;
      s_q        <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sel_q      <= sel;
      sel_p_q    <= sel_q;
      dig_q      <= dig;
      dig_p_q    <= dig_q;
      stab_q     <= stab_d;
      cap_done_q <= cap_done_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      bad_q      <= bad_d;
      code_q     <= code_d;
      timer_q    <= timer_d;
      h_q        <= h_d;
      m_q        <= m_d;
      s_q        <= s_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

endmodule
